// File: rtl/dbg_arb_pkg.sv
// Shared encodings for the debug FIFO write arbiter: FSM states, control codes
// and the position of the control flag inside a FIFO word.
`ifndef DBG_ARB_CTRL_BIT
`define DBG_ARB_CTRL_BIT(w) (w)
`endif

package dbg_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_ABT  = 3'd4
  } arb_state_e;

  localparam logic [7:0] SOF_BASE = 8'h10;
  localparam logic [7:0] EOF_CODE = 8'h20;
  localparam logic [7:0] ABT_CODE = 8'h30;

endpackage

// File: rtl/dbg_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from ptr+1.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
          gnt_id = ID_W'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dbg_fifo_wr_arbiter.sv
// Frame-locked round-robin arbiter in front of the debug FIFO write port; wraps frames in SOF/EOF/ABT.
// SOF is written 1 cycle after a request in IDLE; every write waits on !fifo_full.
module dbg_fifo_wr_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  WIDTH   = 8,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   fifo_wr_en,
  output logic [WIDTH:0]         fifo_wr_data,
  input  logic                   fifo_full,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [7:0]             abort_cnt
);

  arb_state_e       state_q;
  logic [ID_W-1:0]  grant_q, rr_q, pick_id;
  logic             pick_any, busy_q;
  logic [7:0]       abort_q;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             gnt_vld, gnt_last;
  logic [WIDTH-1:0] gnt_byte;
  logic [WIDTH:0]   wr_word;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (rr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign idle_d    = idle_q + CNT_W'(1);
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign abort_cnt = abort_q;

  always_comb begin
    gnt_vld    = 1'b0;
    gnt_last   = 1'b0;
    gnt_byte   = '0;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    wr_word    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_q) begin
        gnt_vld      = req_valid[i];
        gnt_last     = req_last[i];
        gnt_byte     = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = (state_q == ST_DATA) && !fifo_full;
      end
    end
    case (state_q)
      ST_SOF: begin
        fifo_wr_en                         = !fifo_full;
        wr_word[`DBG_ARB_CTRL_BIT(WIDTH)]  = 1'b1;
        wr_word[WIDTH-1:0]                 = WIDTH'(SOF_BASE) | WIDTH'(grant_q);
      end
      ST_DATA: begin
        fifo_wr_en         = gnt_vld && !fifo_full;
        wr_word[WIDTH-1:0] = gnt_byte;
      end
      ST_EOF: begin
        fifo_wr_en                         = !fifo_full;
        wr_word[`DBG_ARB_CTRL_BIT(WIDTH)]  = 1'b1;
        wr_word[WIDTH-1:0]                 = WIDTH'(EOF_CODE);
      end
      ST_ABT: begin
        fifo_wr_en                         = !fifo_full;
        wr_word[`DBG_ARB_CTRL_BIT(WIDTH)]  = 1'b1;
        wr_word[WIDTH-1:0]                 = WIDTH'(ABT_CODE);
      end
      default: ;
    endcase
    fifo_wr_data = fifo_wr_en ? wr_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= ID_W'(N_REQ - 1);
      busy_q  <= 1'b0;
      abort_q <= '0;
      idle_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_id;
            busy_q  <= 1'b1;
            state_q <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (!fifo_full) begin
            idle_q  <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // A stalled-but-valid source holds the counter, so backpressure never aborts.
          if (gnt_vld) begin
            if (!fifo_full) begin
              idle_q <= '0;
              if (gnt_last) state_q <= ST_EOF;
            end
          end else begin
            idle_q <= idle_d;
            if (idle_d == CNT_W'(TIMEOUT)) state_q <= ST_ABT;
          end
        end
        ST_EOF, ST_ABT: begin
          if (!fifo_full) begin
            rr_q    <= grant_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (state_q == ST_ABT && abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
